// File: rtl/acq_pkg.sv
// acq_pkg -- shared definitions for the acquisition/trigger sequencer.
//   STATE_W / ST_*      : state width and state codes seen on the state port
//   acq_state_e         : FSM state type built on the same codes
//   EDGE_RISE/EDGE_FALL : edge_sel encodings
package acq_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_PRE   = 3'd1;
  localparam logic [STATE_W-1:0] ST_ARMED = 3'd2;
  localparam logic [STATE_W-1:0] ST_POST  = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;
  localparam logic [STATE_W-1:0] ST_HOLD  = 3'd5;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_PRE   = ST_PRE,
    S_ARMED = ST_ARMED,
    S_POST  = ST_POST,
    S_DONE  = ST_DONE,
    S_HOLD  = ST_HOLD
  } acq_state_e;

endpackage

// File: rtl/acq_trig_detect.sv
// acq_trig_detect -- remembers the last written sample and flags a
// level crossing on the current sample.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   clr              : invalidate the remembered sample
//   wr               : current sample is being written (update prev)
//   eval             : current sample is eligible to trigger
//   data, level      : current sample and unsigned threshold
//   edge_sel         : EDGE_RISE / EDGE_FALL
//   trig_hit         : combinational, high for the triggering sample only
module acq_trig_detect
  import acq_pkg::*;
#(
  parameter int DW = 12
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          clr,
  input  logic          wr,
  input  logic          eval,
  input  logic [DW-1:0] data,
  input  logic [DW-1:0] level,
  input  logic          edge_sel,
  output logic          trig_hit
);

  logic [DW-1:0] prev;
  logic          prev_vld;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || clr) begin
      prev     <= '0;
      prev_vld <= 1'b0;
    end else if (wr) begin
      prev     <= data;
      prev_vld <= 1'b1;
    end
  end

  always_comb begin
    trig_hit = 1'b0;
    if (eval && prev_vld) begin
      if (edge_sel == EDGE_RISE) trig_hit = (prev < level) && (data >= level);
      else                       trig_hit = (prev > level) && (data <= level);
    end
  end

endmodule

// File: rtl/acq_trig_ctrl.sv
// acq_trig_ctrl -- acquisition/trigger sequencer. Streams ADC samples into a
// circular RAM, freezes a frame with PRE_TRIG samples ahead of the trigger and
// hands it to the sender with a frame_valid/frame_ack handshake.
//   sys_clk, sys_rst            : clock, synchronous active-high reset
//   sample_en, adc_data         : sample strobe and data
//   trig_level, edge_sel        : trigger threshold and edge direction
//   stop, single_mode           : mode levels from the key decoder
//   single_rearm, frame_ack     : re-arm pulse, sender consumed pulse
//   wr_en, wr_addr, wr_data     : RAM write port (1-cycle latency)
//   frame_valid, frame_start    : frozen frame and its oldest address
//   trig_addr, auto_trig, state : trigger address, forced-trigger flag, state
// Optional: define ACQ_AUTO_TRIG_EN to force a trigger after AUTO_TIMEOUT
// ARMED samples without a trigger event.
//
// state | meaning
// IDLE  | stopped, nothing written
// PRE   | filling the pre-trigger history
// ARMED | writing circularly, waiting for a trigger sample
// POST  | writing the post-trigger part of the frame
// DONE  | frame frozen, waiting for frame_ack
// HOLD  | single-shot finished, waiting for single_rearm
module acq_trig_ctrl
  import acq_pkg::*;
#(
  parameter int DW           = 12,
  parameter int DEPTH_LOG2   = 10,
  parameter int PRE_TRIG     = 256,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  sample_en,
  input  logic [DW-1:0]         adc_data,
  input  logic [DW-1:0]         trig_level,
  input  logic                  edge_sel,
  input  logic                  stop,
  input  logic                  single_mode,
  input  logic                  single_rearm,
  input  logic                  frame_ack,
  output logic                  wr_en,
  output logic [DEPTH_LOG2-1:0] wr_addr,
  output logic [DW-1:0]         wr_data,
  output logic                  frame_valid,
  output logic [DEPTH_LOG2-1:0] frame_start,
  output logic [DEPTH_LOG2-1:0] trig_addr,
  output logic                  auto_trig,
  output logic [STATE_W-1:0]    state
);

  localparam int AW = DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] PRE_TC  = CW'(PRE_TRIG);
  localparam logic [CW-1:0] POST_TC = CW'((1 << DEPTH_LOG2) - PRE_TRIG);

  if (PRE_TRIG < 1 || PRE_TRIG > (1 << DEPTH_LOG2) - 1) begin : g_bad_pre_trig
    $error("acq_trig_ctrl: PRE_TRIG out of range");
  end
  if (AUTO_TIMEOUT < 1) begin : g_bad_auto_timeout
    $error("acq_trig_ctrl: AUTO_TIMEOUT must be at least 1");
  end

  acq_state_e    state_q, state_nx;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] pre_cnt, post_cnt;
  logic          wr_accept, enter_pre, trig_hit, auto_fire, fire;

  // stop in a writing state wins over the sample, so it is never written
  assign wr_accept = sample_en && !stop &&
                     (state_q inside {S_PRE, S_ARMED, S_POST});
  assign fire      = wr_accept && (state_q == S_ARMED) && (trig_hit || auto_fire);

  acq_trig_detect #(.DW(DW)) u_detect (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .clr      (enter_pre),
    .wr       (wr_accept),
    .eval     (wr_accept && (state_q == S_ARMED)),
    .data     (adc_data),
    .level    (trig_level),
    .edge_sel (edge_sel),
    .trig_hit (trig_hit)
  );

  always_comb begin
    state_nx  = state_q;
    enter_pre = 1'b0;
    case (state_q)
      S_IDLE: if (!stop) begin
        state_nx  = S_PRE;
        enter_pre = 1'b1;
      end
      S_PRE: begin
        if (stop) state_nx = S_IDLE;
        else if (wr_accept && (pre_cnt + CW'(1) == PRE_TC)) state_nx = S_ARMED;
      end
      S_ARMED: begin
        if (stop) state_nx = S_IDLE;
        else if (fire) state_nx = (POST_TC == CW'(1)) ? S_DONE : S_POST;
      end
      S_POST: begin
        if (stop) state_nx = S_IDLE;
        else if (wr_accept && (post_cnt + CW'(1) == POST_TC)) state_nx = S_DONE;
      end
      S_DONE: if (frame_ack) begin
        if (stop) state_nx = S_IDLE;
        else if (single_mode) state_nx = S_HOLD;
        else begin
          state_nx  = S_PRE;
          enter_pre = 1'b1;
        end
      end
      S_HOLD: begin
        if (stop) state_nx = S_IDLE;
        else if (single_rearm) begin
          state_nx  = S_PRE;
          enter_pre = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      wr_ptr    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      trig_addr <= '0;
    end else begin
      state_q <= state_nx;
      wr_en   <= wr_accept;
      if (wr_accept) begin
        wr_addr <= wr_ptr;
        wr_data <= adc_data;
        wr_ptr  <= wr_ptr + AW'(1);
      end
      if (enter_pre) pre_cnt <= '0;
      else if (wr_accept && state_q == S_PRE) pre_cnt <= pre_cnt + CW'(1);
      if (fire) begin
        trig_addr <= wr_ptr;
        post_cnt  <= CW'(1);
      end else if (wr_accept && state_q == S_POST) begin
        post_cnt <= post_cnt + CW'(1);
      end
    end
  end

`ifdef ACQ_AUTO_TRIG_EN
  localparam int TW = $clog2(AUTO_TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  logic          auto_q;

  // down-counter loaded on ARMED entry; the sample seen at terminal count is
  // the AUTO_TIMEOUT-th ARMED sample and becomes the forced trigger
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tmo_cnt <= '0;
      auto_q  <= 1'b0;
    end else begin
      if (state_nx == S_ARMED && state_q != S_ARMED) tmo_cnt <= TW'(AUTO_TIMEOUT - 1);
      else if (wr_accept && state_q == S_ARMED && tmo_cnt != '0) tmo_cnt <= tmo_cnt - TW'(1);
      if (fire) auto_q <= !trig_hit;
      else if (enter_pre || (state_q == S_DONE && frame_ack)) auto_q <= 1'b0;
    end
  end

  assign auto_fire = (state_q == S_ARMED) && (tmo_cnt == '0);
  assign auto_trig = auto_q;
`else
  assign auto_fire = 1'b0;
  assign auto_trig = 1'b0;
`endif

  assign state       = state_q;
  assign frame_valid = (state_q == S_DONE);
  assign frame_start = (state_q == S_DONE) ? trig_addr - AW'(PRE_TRIG) : '0;

endmodule

// File: tb/tb_acq_trig_ctrl.sv
module tb_acq_trig_ctrl;
  import acq_pkg::*;

  localparam int DW = 12;
  localparam int AW = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          sample_en = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic [DW-1:0] trig_level = 12'd8;
  logic          edge_sel = EDGE_RISE;
  logic          stop = 1'b0;
  logic          single_mode = 1'b0;
  logic          single_rearm = 1'b0;
  logic          frame_ack = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          frame_valid;
  logic [AW-1:0] frame_start;
  logic [AW-1:0] trig_addr;
  logic          auto_trig;
  logic [2:0]    state;

  int n_cmp = 0;
  int n_err = 0;
  logic [AW-1:0] exp_ptr = '0;
  int n_sent;

  acq_trig_ctrl #(
    .DW(DW), .DEPTH_LOG2(AW), .PRE_TRIG(4), .AUTO_TIMEOUT(6)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .sample_en(sample_en),
    .adc_data(adc_data), .trig_level(trig_level), .edge_sel(edge_sel),
    .stop(stop), .single_mode(single_mode), .single_rearm(single_rearm),
    .frame_ack(frame_ack), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_valid(frame_valid), .frame_start(frame_start),
    .trig_addr(trig_addr), .auto_trig(auto_trig), .state(state)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // one sample strobe followed by two idle cycles
  task automatic send_sample(input logic [DW-1:0] v, input bit exp_wr);
    sample_en = 1'b1;
    adc_data  = v;
    tick();
    sample_en = 1'b0;
    if (exp_wr) begin
      check_val("wr_en", 32'(wr_en), 1);
      check_val("wr_addr", 32'(wr_addr), 32'(exp_ptr));
      check_val("wr_data", 32'(wr_data), 32'(v));
      exp_ptr = exp_ptr + 4'd1;
    end else begin
      check_val("wr_en_idle", 32'(wr_en), 0);
    end
    tick();
    tick();
  endtask

  task automatic pulse_ack();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_wr_en"}, 32'(wr_en), 0);
    check_val({tag, "_wr_addr"}, 32'(wr_addr), 0);
    check_val({tag, "_wr_data"}, 32'(wr_data), 0);
    check_val({tag, "_frame_valid"}, 32'(frame_valid), 0);
    check_val({tag, "_frame_start"}, 32'(frame_start), 0);
    check_val({tag, "_trig_addr"}, 32'(trig_addr), 0);
    check_val({tag, "_auto_trig"}, 32'(auto_trig), 0);
    check_val({tag, "_state"}, 32'(state), 0);
  endtask

  initial begin
    // reset
    tick();
    tick();
    check_reset_outputs("reset");
    sys_rst = 1'b0;
    tick();
    check_val("idle_to_pre", 32'(state), 1);

    // basic rising-edge frame
    for (int i = 0; i < 4; i++) send_sample(12'(i), 1'b1);
    check_val("pre_to_armed", 32'(state), 2);
    for (int i = 4; i < 8; i++) send_sample(12'(i), 1'b1);
    check_val("armed_no_trig", 32'(state), 2);
    send_sample(12'd8, 1'b1);
    check_val("trig_to_post", 32'(state), 3);
    check_val("trig_addr_rise", 32'(trig_addr), 8);
    for (int i = 9; i < 19; i++) send_sample(12'(i), 1'b1);
    check_val("post_not_done", 32'(state), 3);
    send_sample(12'd19, 1'b1);
    check_val("basic_done", 32'(state), 4);
    check_val("basic_valid", 32'(frame_valid), 1);
    check_val("basic_start", 32'(frame_start), 4);
    check_val("basic_auto", 32'(auto_trig), 0);
    send_sample(12'd20, 1'b0);
    check_val("done_holds", 32'(frame_valid), 1);
    pulse_ack();
    check_val("ack_valid", 32'(frame_valid), 0);
    check_val("ack_to_pre", 32'(state), 1);

    // falling edge, descending ramp; trigger on value 8 at addr 11
    edge_sel = EDGE_FALL;
    n_sent = 0;
    for (int i = 0; i < 40; i++) begin
      if (state == ST_DONE) break;
      send_sample(12'((15 - i) & 15), 1'b1);
      n_sent++;
    end
    check_val("fall_total_writes", 32'(n_sent), 19);
    check_val("fall_post_writes", 32'(n_sent - 7), 12);
    check_val("fall_trig_addr", 32'(trig_addr), 11);
    check_val("fall_start", 32'(frame_start), 7);
    check_val("fall_valid", 32'(frame_valid), 1);

    // single-shot: ack goes to HOLD, nothing written there
    single_mode = 1'b1;
    pulse_ack();
    check_val("single_hold", 32'(state), 5);
    for (int i = 0; i < 3; i++) send_sample(12'(i), 1'b0);
    pulse_ack();
    check_val("hold_ignores_ack", 32'(state), 5);
    single_rearm = 1'b1;
    tick();
    single_rearm = 1'b0;
    check_val("rearm_to_pre", 32'(state), 1);
    single_mode = 1'b0;
    edge_sel = EDGE_RISE;

    // stop after three POST writes
    for (int i = 0; i < 11; i++) send_sample(12'(i), 1'b1);
    check_val("stop_pre_post", 32'(state), 3);
    check_val("stop_trig_addr", 32'(trig_addr), 15);
    stop = 1'b1;
    tick();
    check_val("stop_to_idle", 32'(state), 0);
    send_sample(12'd11, 1'b0);
    check_val("stop_no_frame", 32'(frame_valid), 0);

    // stop in the same cycle as the trigger sample
    stop = 1'b0;
    tick();
    check_val("restart_pre", 32'(state), 1);
    for (int i = 0; i < 8; i++) send_sample(12'(i), 1'b1);
    check_val("stop_trig_armed", 32'(state), 2);
    sample_en = 1'b1;
    adc_data  = 12'd8;
    stop      = 1'b1;
    tick();
    sample_en = 1'b0;
    check_val("stop_trig_no_write", 32'(wr_en), 0);
    check_val("stop_trig_idle", 32'(state), 0);
    tick();
    tick();

    // reset while ARMED
    stop = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) send_sample(12'(i), 1'b1);
    check_val("rst_armed", 32'(state), 2);
    sys_rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    sys_rst = 1'b0;
    exp_ptr = '0;

`ifdef ACQ_AUTO_TRIG_EN
    // forced trigger on the 6th ARMED sample of a constant input
    tick();
    n_sent = 0;
    for (int i = 0; i < 40; i++) begin
      if (state == ST_DONE) break;
      send_sample(12'd3, 1'b1);
      n_sent++;
    end
    check_val("auto_writes", 32'(n_sent), 21);
    check_val("auto_trig_addr", 32'(trig_addr), 9);
    check_val("auto_start", 32'(frame_start), 5);
    check_val("auto_valid", 32'(frame_valid), 1);
    check_val("auto_flag", 32'(auto_trig), 1);
    pulse_ack();
    check_val("auto_flag_clr", 32'(auto_trig), 0);
    check_val("auto_ack_pre", 32'(state), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
